xps2tx: RTL and testbench

PS/2 host-to-device transmitter peripheral on the controller data bus, complementing the PS/2 receive path. A controller write of one byte is serialised as a PS/2 host-to-device frame: inhibit, request-to-send, start, 8 data bits LSB-first, odd parity, stop, and device ACK. It is used, for example, to send keyboard LED and configuration commands. Status is readable for software polling.

---
 rtl/xps2tx_if.sv | 29 ++
 rtl/xps2tx.sv | 201 ++++++++++++++++++++
 tb/tb_xps2tx.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/xps2tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : xps2tx_if
//  Brief    : Bus and PS/2 pad bundle for the PS/2 host-to-device transmitter.
//             The slave modport is the peripheral view; master is the
//             controller/pad side.
//  Revision : 1.0 - initial release
// ============================================================================
interface xps2tx_if;
    logic       sel;
    logic       we;
    logic [7:0] data_in;
    logic [2:0] data_out;
    logic       ps2_clk;
    logic       ps2_data;
    logic       ps2_clk_low;
    logic       ps2_data_low;

    modport slave (
        input  sel, we, data_in, ps2_clk, ps2_data,
        output data_out, ps2_clk_low, ps2_data_low
    );

    modport master (
        output sel, we, data_in, ps2_clk, ps2_data,
        input  data_out, ps2_clk_low, ps2_data_low
    );
endinterface
`default_nettype wire

// File: rtl/xps2tx.sv
`default_nettype none
// ============================================================================
//  Module   : xps2tx
//  Brief    : PS/2 host-to-device transmitter. A bus write of one byte is sent
//             as inhibit, request-to-send, start, 8 data bits LSB first, odd
//             parity, stop, then the device ACK is checked. Status
//             {err, done, busy} is readable at any time.
//  Revision : 1.0 - initial release
// ============================================================================
module xps2tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int SETUP_CYCLES   = 50,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  wire logic  clk,
    input  wire logic  rst,
    xps2tx_if.slave    bus
);

    localparam int MAX_A   = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
    localparam int CNT_MAX = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_REQ       = 3'd2,
        S_TX        = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      n_q, n_d;
    logic [7:0]      byte_q, byte_d;
    logic            par_q, par_d;
    logic            clk_low_q, clk_low_d;
    logic            data_low_q, data_low_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            busy_q;
    logic [1:0]      clk_s_q;
    logic [1:0]      data_s_q;
    logic            clk_prev_q;

    logic            w_clk_sync;
    logic            w_data_sync;
    logic            w_fe;

    assign w_clk_sync  = clk_s_q[1];
    assign w_data_sync = data_s_q[1];
    // Edge register lags the second stage by one cycle, so fe is a one-cycle pulse.
    assign w_fe        = clk_prev_q & ~clk_s_q[1];

    assign bus.ps2_clk_low  = clk_low_q;
    assign bus.ps2_data_low = data_low_q;
    assign bus.data_out     = {err_q, done_q, busy_q};

    // Pad synchronisers and falling-edge history; idle bus level is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s_q    <= 2'b11;
            data_s_q   <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            clk_s_q    <= {clk_s_q[0], bus.ps2_clk};
            data_s_q   <= {data_s_q[0], bus.ps2_data};
            clk_prev_q <= clk_s_q[1];
        end
    end

    // State, counters, frame data and registered drive/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            n_q        <= '0;
            byte_q     <= '0;
            par_q      <= 1'b0;
            clk_low_q  <= 1'b0;
            data_low_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            byte_q     <= byte_d;
            par_q      <= par_d;
            clk_low_q  <= clk_low_d;
            data_low_q <= data_low_d;
            done_q     <= done_d;
            err_q      <= err_d;
            busy_q     <= (state_d != S_IDLE);
        end
    end

    // Next-state logic; drive levels are computed for the state being entered.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        byte_d     = byte_q;
        par_d      = par_q;
        clk_low_d  = clk_low_q;
        data_low_d = data_low_q;
        done_d     = done_q;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                clk_low_d  = 1'b0;
                data_low_d = 1'b0;
                if (bus.sel && bus.we) begin
                    byte_d    = bus.data_in;
                    par_d     = ~^bus.data_in;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    cnt_d     = '0;
                    clk_low_d = 1'b1;
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
                    cnt_d      = '0;
                    data_low_d = 1'b1;
                    state_d    = S_REQ;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_REQ: begin
                if (cnt_q == CW'(SETUP_CYCLES - 1)) begin
                    cnt_d     = '0;
                    n_d       = '0;
                    clk_low_d = 1'b0;
                    state_d   = S_TX;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_TX: begin
                // A device edge takes priority over an expiring timeout.
                if (w_fe) begin
                    cnt_d = '0;
                    n_d   = n_q + 4'd1;
                    if (n_q < 4'd8) begin
                        data_low_d = ~byte_q[n_q[2:0]];
                    end else if (n_q == 4'd8) begin
                        data_low_d = ~par_q;
                    end else if (n_q == 4'd9) begin
                        data_low_d = 1'b0;
                    end else begin
                        data_low_d = 1'b0;
                        if (w_data_sync) begin
                            err_d = 1'b1;
                        end
                        state_d = S_WAIT_IDLE;
                    end
                end else if (cnt_q == CW'(TIMEOUT_CYCLES)) begin
                    cnt_d      = '0;
                    clk_low_d  = 1'b0;
                    data_low_d = 1'b0;
                    err_d      = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_IDLE: begin
                clk_low_d  = 1'b0;
                data_low_d = 1'b0;
                if (w_clk_sync && w_data_sync) begin
                    if (!err_q) begin
                        done_d = 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (w_fe) begin
                    cnt_d = '0;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES)) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                clk_low_d  = 1'b0;
                data_low_d = 1'b0;
                cnt_d      = '0;
                state_d    = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_xps2tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xps2tx
//  Brief    : Directed bench for xps2tx with an open-drain PS/2 device model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_xps2tx;

    localparam int INH = 20;
    localparam int SET = 5;
    localparam int TO  = 300;
    localparam int H   = 10;   // device clock half period in clk cycles

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;

    int n_vec  = 0;
    int n_miss = 0;

    xps2tx_if bus ();

    xps2tx #(
        .INHIBIT_CYCLES (INH),
        .SETUP_CYCLES   (SET),
        .TIMEOUT_CYCLES (TO)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Open-drain wired-AND of host and device pull-downs.
    assign bus.ps2_clk  = ~(bus.ps2_clk_low  | dev_clk_low);
    assign bus.ps2_data = ~(bus.ps2_data_low | dev_data_low);

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [7:0] b);
        @(negedge clk);
        bus.sel     = 1'b1;
        bus.we      = 1'b1;
        bus.data_in = b;
        @(negedge clk);
        bus.sel     = 1'b0;
        bus.we      = 1'b0;
    endtask

    // Device: waits for request-to-send, then issues nclk clock pulses,
    // sampling data before each rising edge; ACKs on the 11th if asked.
    task automatic dev_frame(input int nclk, input bit ack, output logic [10:0] bits);
        int w;
        bits = '1;
        w = 0;
        while (!(bus.ps2_data_low && !bus.ps2_clk_low) && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 2000) check("req_wait", 32'd0, 32'd1);
        repeat (4) @(negedge clk);
        bits[0] = bus.ps2_data;
        for (int k = 1; k <= nclk; k++) begin
            if (k == 11 && ack) dev_data_low = 1'b1;
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            if (k <= 10) bits[k] = bus.ps2_data;
            dev_clk_low = 1'b0;
            repeat (H) @(negedge clk);
        end
        dev_data_low = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int w;
        w = 0;
        while (bus.data_out[0] && w < budget) begin
            @(negedge clk);
            w++;
        end
        if (w >= budget) check("busy_wait", 32'd0, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    logic [10:0] fr;
    int          cnt;

    initial begin
        bus.sel     = 1'b0;
        bus.we      = 1'b0;
        bus.data_in = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_status",   32'(bus.data_out),     32'd0);
        check("rst_clk_low",  32'(bus.ps2_clk_low),  32'd0);
        check("rst_data_low", 32'(bus.ps2_data_low), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 0xED with phase timing
        do_write(8'hED);
        check("busy_after_wr", 32'(bus.data_out), 32'd1);
        cnt = 0;
        while (bus.ps2_clk_low && !bus.ps2_data_low && cnt < 1000) begin cnt++; @(negedge clk); end
        check("inhibit_len", 32'(cnt), 32'(INH));
        cnt = 0;
        while (bus.ps2_clk_low && bus.ps2_data_low && cnt < 1000) begin cnt++; @(negedge clk); end
        check("setup_len", 32'(cnt), 32'(SET));
        dev_frame(11, 1'b1, fr);
        wait_idle(500);
        check("ed_start",  32'(fr[0]),   32'd0);
        check("ed_byte",   32'(fr[8:1]), 32'hED);
        check("ed_parity", 32'(fr[9]),   32'd1);
        check("ed_stop",   32'(fr[10]),  32'd1);
        check("ed_status", 32'(bus.data_out), 32'b010);

        // parity corners
        do_write(8'h00);
        dev_frame(11, 1'b1, fr);
        wait_idle(500);
        check("00_byte",   32'(fr[8:1]), 32'h00);
        check("00_parity", 32'(fr[9]),   32'd1);
        do_write(8'h01);
        dev_frame(11, 1'b1, fr);
        wait_idle(500);
        check("01_byte",   32'(fr[8:1]), 32'h01);
        check("01_parity", 32'(fr[9]),   32'd0);
        check("01_status", 32'(bus.data_out), 32'b010);

        // no ACK on 11th clock
        do_write(8'h55);
        dev_frame(11, 1'b0, fr);
        wait_idle(500);
        check("nack_status", 32'(bus.data_out), 32'b100);

        // device stops clocking after 4 bits
        do_write(8'hF0);
        dev_frame(4, 1'b1, fr);
        wait_idle(TO + 100);
        check("to_clk_low",  32'(bus.ps2_clk_low),  32'd0);
        check("to_data_low", 32'(bus.ps2_data_low), 32'd0);
        check("to_status",   32'(bus.data_out),     32'b100);
        do_write(8'hA5);
        check("to_err_clr", 32'(bus.data_out), 32'b001);
        dev_frame(11, 1'b1, fr);
        wait_idle(500);
        check("a5_byte",   32'(fr[8:1]), 32'hA5);
        check("a5_parity", 32'(fr[9]),   32'd1);
        check("a5_status", 32'(bus.data_out), 32'b010);

        // write while busy is ignored
        do_write(8'h5A);
        repeat (3) @(negedge clk);
        do_write(8'hFF);
        check("busy_wr_status", 32'(bus.data_out), 32'b001);
        dev_frame(11, 1'b1, fr);
        wait_idle(500);
        check("busy_wr_byte",   32'(fr[8:1]), 32'h5A);
        check("busy_wr_parity", 32'(fr[9]),   32'd1);
        check("busy_wr_status2", 32'(bus.data_out), 32'b010);

        // reset during request-to-send
        do_write(8'h3C);
        cnt = 0;
        while (!bus.ps2_data_low && cnt < 1000) begin cnt++; @(negedge clk); end
        check("req_reached", 32'(bus.ps2_data_low), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rrst_clk_low",  32'(bus.ps2_clk_low),  32'd0);
        check("rrst_data_low", 32'(bus.ps2_data_low), 32'd0);
        check("rrst_status",   32'(bus.data_out),     32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        do_write(8'h81);
        dev_frame(11, 1'b1, fr);
        wait_idle(500);
        check("81_byte",   32'(fr[8:1]), 32'h81);
        check("81_parity", 32'(fr[9]),   32'd1);
        check("81_status", 32'(bus.data_out), 32'b010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Hard stop in case a loop somewhere fails to terminate.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
